// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline sequencer: stall vectors, exception codes,
// FSM encodings and the stall-merge helpers.
package pipe_ctrl_pkg;

  localparam int unsigned STALL_W = 6;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned WD_W    = 16;

  typedef logic [STALL_W-1:0] stall_vec_t;

  localparam logic        STOP       = 1'b1;
  localparam logic        NO_STOP    = 1'b0;
  localparam logic        RST_ENABLE = 1'b1;
  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

  localparam stall_vec_t STALL_NONE     = 6'b000000;
  localparam stall_vec_t STALL_FROM_IF  = 6'b000011;
  localparam stall_vec_t STALL_FROM_ID  = 6'b000111;
  localparam stall_vec_t STALL_FROM_EX  = 6'b001111;
  localparam stall_vec_t STALL_FROM_MEM = 6'b011111;

  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  localparam logic [0:0] CTRL_RUN   = 1'b0;
  localparam logic [0:0] CTRL_FLUSH = 1'b1;

  // Deepest requesting stage wins; every result is prefix-form.
  function automatic stall_vec_t stall_merge(input logic req_mem, input logic req_ex,
                                             input logic req_id, input logic req_if);
    stall_vec_t v;
    v = STALL_NONE;
    if (req_mem)     v = STALL_FROM_MEM;
    else if (req_ex) v = STALL_FROM_EX;
    else if (req_id) v = STALL_FROM_ID;
    else if (req_if) v = STALL_FROM_IF;
    return v;
  endfunction

  // True when the ones are contiguous from bit0 (a single bubble point).
  function automatic logic is_prefix_stall(input stall_vec_t v);
    stall_vec_t inc;
    inc = v + STALL_W'(1);
    return (v & inc) == STALL_NONE;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/control bundle between the core pipeline and the sequencer.
interface pipe_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic              stallreq_if;
  logic              stallreq_id;
  logic              stallreq_ex;
  logic              stallreq_mem;
  logic [31:0]       excepttype;
  logic [31:0]       cp0_epc;
  logic [5:0]        stall;
  logic              flush;
  logic [31:0]       new_pc;
  logic [CNT_W-1:0]  stall_cnt;
  logic              timeout;

  modport master (
    output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, excepttype, cp0_epc,
    input  stall, flush, new_pc, stall_cnt, timeout
  );

  modport slave (
    input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, excepttype, cp0_epc,
    output stall, flush, new_pc, stall_cnt, timeout
  );
endinterface

// File: rtl/pipe_ctrl_stall_watchdog.sv
// Stall accounting: saturating total-stall counter, consecutive-stall counter
// and the sticky watchdog flag.
module pipe_ctrl_stall_watchdog
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_stall_active,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic             o_timeout
);

  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0]  r_consec;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             r_timeout;

  // Counters saturate rather than wrap; timeout only clears on reset.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      r_consec    <= '0;
      r_stall_cnt <= '0;
      r_timeout   <= 1'b0;
    end else if (i_stall_active) begin
      if (r_consec != '1)     r_consec    <= r_consec + WD_W'(1);
      if (r_stall_cnt != '1)  r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (r_consec >= WD_LIMIT) r_timeout <= 1'b1;
    end else begin
      r_consec <= '0;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_timeout   = r_timeout;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stage stall requests into the stall vector and
// turns MEM-stage exceptions/ERET into a one-cycle flush with redirect PC.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR     = 32'h0000_0020,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 32
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  logic [0:0]  r_state;
  logic [0:0]  w_next_state;
  logic        r_flush;
  logic [31:0] r_new_pc;
  logic        w_take_exc;
  logic [31:0] w_target;
  stall_vec_t  w_stall;
  logic [CNT_W-1:0] w_stall_cnt;
  logic        w_timeout;

  assign w_target = (bus.excepttype == EXC_ERET) ? bus.cp0_epc : EXC_VECTOR;

  // Next state, exception acceptance and the combinational stall vector.
  always_comb begin
    w_next_state = r_state;
    w_take_exc   = 1'b0;
    w_stall      = STALL_NONE;
    case (r_state)
      CTRL_RUN: begin
        w_stall = stall_merge(bus.stallreq_mem, bus.stallreq_ex,
                              bus.stallreq_id, bus.stallreq_if);
        if (bus.excepttype != ZERO_WORD && !bus.stallreq_mem) begin
          w_take_exc   = 1'b1;
          w_next_state = CTRL_FLUSH;
        end
      end
      CTRL_FLUSH: w_next_state = CTRL_RUN;
      default:    w_next_state = CTRL_RUN;
    endcase
    if (rst == RST_ENABLE) w_stall = STALL_NONE;
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      r_state  <= CTRL_RUN;
      r_flush  <= 1'b0;
      r_new_pc <= ZERO_WORD;
    end else begin
      r_state <= w_next_state;
      r_flush <= w_take_exc;
      if (w_take_exc) r_new_pc <= w_target;
    end
  end

  pipe_ctrl_stall_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_watchdog (
    .clk            (clk),
    .rst            (rst),
    .i_stall_active (w_stall != STALL_NONE),
    .o_stall_cnt    (w_stall_cnt),
    .o_timeout      (w_timeout)
  );

  assign bus.stall     = w_stall;
  assign bus.flush     = r_flush;
  assign bus.new_pc    = r_new_pc;
  assign bus.stall_cnt = w_stall_cnt;
  assign bus.timeout   = w_timeout;

  a_stall_prefix: assert property (@(posedge clk) is_prefix_stall(w_stall));
  a_flush_single: assert property (@(posedge clk) disable iff (rst) r_flush |=> !r_flush);
  a_timeout_sticky: assert property (@(posedge clk) disable iff (rst) w_timeout |=> w_timeout);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with a short watchdog and narrow stall counter.
module tb_pipe_ctrl;

  localparam int unsigned CNT_W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_ctrl #(
    .EXC_VECTOR     (32'h0000_0020),
    .TIMEOUT_CYCLES (4),
    .CNT_W          (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Index is {mem, ex, id, if}.
  logic [5:0] exp_tbl [16] = '{6'h00, 6'h03, 6'h07, 6'h07, 6'h0F, 6'h0F, 6'h0F, 6'h0F,
                               6'h1F, 6'h1F, 6'h1F, 6'h1F, 6'h1F, 6'h1F, 6'h1F, 6'h1F};

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [3:0] r);
    bus.stallreq_mem = r[3];
    bus.stallreq_ex  = r[2];
    bus.stallreq_id  = r[1];
    bus.stallreq_if  = r[0];
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_req(4'b0000);
    bus.excepttype = 32'h0;
    bus.cp0_epc    = 32'h0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset with every request high
    rst = 1'b1;
    set_req(4'b1111);
    bus.excepttype = 32'h0;
    bus.cp0_epc    = 32'h0;
    tick();
    tick();
    check_eq("rst_stall",     32'(bus.stall), 32'h00);
    check_eq("rst_flush",     32'(bus.flush), 32'h0);
    check_eq("rst_stall_cnt", 32'(bus.stall_cnt), 32'h0);
    check_eq("rst_timeout",   32'(bus.timeout), 32'h0);
    check_eq("rst_new_pc",    bus.new_pc, 32'h0);
    rst = 1'b0;
    #1;
    check_eq("release_stall", 32'(bus.stall), 32'h1F);
    tick();
    check_eq("release_cnt",   32'(bus.stall_cnt), 32'h1);

    // Priority table over all request combinations
    for (int i = 0; i < 16; i++) begin
      set_req(4'(i));
      #1;
      check_eq($sformatf("prio_%0d", i), 32'(bus.stall), 32'(exp_tbl[i]));
    end

    // ID + IF together for three cycles
    do_reset();
    set_req(4'b0011);
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq($sformatf("id_if_stall_%0d", i), 32'(bus.stall), 32'h07);
      tick();
    end
    set_req(4'b0000);
    check_eq("id_if_cnt",     32'(bus.stall_cnt), 32'h3);
    check_eq("id_if_timeout", 32'(bus.timeout), 32'h0);
    tick();
    check_eq("id_if_cnt_hold", 32'(bus.stall_cnt), 32'h3);

    // Exception held off by MEM stall, taken after release
    do_reset();
    bus.excepttype = 32'h0000_0008;
    set_req(4'b1000);
    #1;
    check_eq("exc_held_stall", 32'(bus.stall), 32'h1F);
    tick();
    check_eq("exc_held_flush0", 32'(bus.flush), 32'h0);
    tick();
    check_eq("exc_held_flush1", 32'(bus.flush), 32'h0);
    set_req(4'b0000);
    #1;
    check_eq("exc_release_stall", 32'(bus.stall), 32'h00);
    tick();
    check_eq("exc_flush",  32'(bus.flush), 32'h1);
    check_eq("exc_new_pc", bus.new_pc, 32'h0000_0020);
    bus.excepttype = 32'h0;
    tick();
    check_eq("exc_flush_drop", 32'(bus.flush), 32'h0);
    check_eq("exc_pc_hold",    bus.new_pc, 32'h0000_0020);
    check_eq("exc_stall_cnt",  32'(bus.stall_cnt), 32'h2);

    // ERET redirect to EPC; stall suppressed during flush
    bus.excepttype = 32'h0000_000e;
    bus.cp0_epc    = 32'h8000_1234;
    tick();
    check_eq("eret_flush",  32'(bus.flush), 32'h1);
    check_eq("eret_new_pc", bus.new_pc, 32'h8000_1234);
    bus.excepttype = 32'h0;
    set_req(4'b0100);
    #1;
    check_eq("eret_flush_stall", 32'(bus.stall), 32'h00);
    tick();
    check_eq("eret_pulse_width", 32'(bus.flush), 32'h0);
    check_eq("eret_run_stall",   32'(bus.stall), 32'h0F);
    check_eq("eret_pc_hold",     bus.new_pc, 32'h8000_1234);
    set_req(4'b0000);

    // Watchdog with TIMEOUT_CYCLES = 4
    do_reset();
    set_req(4'b0100);
    tick();
    tick();
    tick();
    check_eq("wd_not_yet", 32'(bus.timeout), 32'h0);
    tick();
    check_eq("wd_fire", 32'(bus.timeout), 32'h1);
    set_req(4'b0000);
    tick();
    tick();
    check_eq("wd_sticky",    32'(bus.timeout), 32'h1);
    check_eq("wd_stall_cnt", 32'(bus.stall_cnt), 32'h4);
    do_reset();
    check_eq("wd_rst_clear", 32'(bus.timeout), 32'h0);

    // Back-to-back exceptions
    bus.excepttype = 32'h0000_0008;
    tick();
    check_eq("b2b_n1", 32'(bus.flush), 32'h1);
    tick();
    check_eq("b2b_n2", 32'(bus.flush), 32'h0);
    tick();
    check_eq("b2b_n3", 32'(bus.flush), 32'h1);
    bus.excepttype = 32'h0;
    tick();
    check_eq("b2b_n4", 32'(bus.flush), 32'h0);

    // Reset arriving during a flush
    bus.excepttype = 32'h0000_0008;
    tick();
    check_eq("midrst_flush", 32'(bus.flush), 32'h1);
    rst = 1'b1;
    bus.excepttype = 32'h0;
    tick();
    check_eq("midrst_drop", 32'(bus.flush), 32'h0);
    check_eq("midrst_pc",   bus.new_pc, 32'h0);
    rst = 1'b0;
    tick();
    check_eq("midrst_no_residual", 32'(bus.flush), 32'h0);

    // Stall counter saturation at 4 bits
    do_reset();
    set_req(4'b1000);
    repeat (20) tick();
    check_eq("cnt_saturate", 32'(bus.stall_cnt), 32'hF);
    check_eq("sat_timeout",  32'(bus.timeout), 32'h1);
    set_req(4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the 5-stage MIPS core.
- Merges per-stage stall requests into the 6-bit stall vector consumed by the PC register and every pipeline latch (if_id, id_ex, ex_mem, mem_wb).
- Sequences exception/ERET flushes: a registered one-cycle flush plus the redirect PC.
- Keeps a stall-cycle performance counter and a stall watchdog.

Parameters:
- EXC_VECTOR, 32'h0000_0020, redirect PC for every exception other than ERET.
- TIMEOUT_CYCLES, 1024, consecutive non-zero-stall cycles before the watchdog fires (legal range 2..65535).
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk  in  1  core clock, all state on rising edge
- rst  in  1  synchronous, active-high reset (`RstEnable` = 1'b1)
- stallreq_if  in  1  fetch not ready (icache/bus miss)
- stallreq_id  in  1  load-use hazard
- stallreq_ex  in  1  multi-cycle EX op (div, madd/msub)
- stallreq_mem  in  1  data bus busy
- excepttype  in  32  exception code from MEM stage; 0 = none; `ExcERET` = 32'h0000_000e
- cp0_epc  in  32  current EPC from cp0
- stall  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = `Stop`
- flush  out  1  clear all pipeline latches and load new_pc
- new_pc  out  32  redirect target, valid while flush = 1
- stall_cnt  out  CNT_W  total cycles with stall != 0
- timeout  out  1  sticky watchdog flag

Behaviour:
- Reset (synchronous, rst = 1 at a rising edge) sets: state RUN, flush 0, new_pc 0, stall_cnt 0, timeout 0, and the internal consecutive-stall counter 0. While rst = 1, stall = 6'b000000.
- Stall vector (combinational from requests, state RUN), fixed priority:
  - stallreq_mem → 6'b011111
  - else stallreq_ex → 6'b001111
  - else stallreq_id → 6'b000111
  - else stallreq_if → 6'b000011
  - else 6'b000000
- The vector is always prefix-form (ones contiguous from bit0), so exactly one latch inserts a bubble (stall[k] = Stop, stall[k+1] = NoStop). A non-prefix pattern is illegal and must never be produced.
- FSM states: RUN and FLUSH.
  - RUN → FLUSH when excepttype != 0 and stallreq_mem = 0. At that edge: flush <= 1; new_pc <= cp0_epc if excepttype = `ExcERET`, else EXC_VECTOR.
  - Exception with stallreq_mem = 1: not taken. MEM is held, so excepttype persists and is taken on the first cycle stallreq_mem = 0. No separate pending storage.
  - FLUSH → RUN unconditionally after one cycle. At that edge flush <= 0; new_pc holds its value.
  - In FLUSH: stall forced to 6'b000000 regardless of requests; excepttype is ignored (the source is being flushed).
- Flush latency: exception visible in cycle N → flush = 1 in cycle N+1 only. Back-to-back exceptions produce flush pulses at least 2 cycles apart.
- stall_cnt: +1 on each edge where the stall output was non-zero. Saturates at all-ones, no wrap.
- Watchdog:
  - The consecutive counter (16 bits) increments while stall != 0 and clears whenever stall = 0.
  - When it reaches TIMEOUT_CYCLES-1 with stall still != 0, timeout <= 1.
  - timeout is sticky until rst. The counter saturates and does not wrap.
- Reset mid-flush: state returns to RUN and flush drops at that edge, with no residual pulse.

Decomposition:
- Shared defines.v gains:
  - stall vector constants STALL_NONE, STALL_FROM_IF, STALL_FROM_ID, STALL_FROM_EX, STALL_FROM_MEM
  - `ExcERET`
  - state encodings CTRL_RUN, CTRL_FLUSH
  - existing `Stop`/`NoStop`/`RstEnable`/`ZeroWord` are reused.
- One natural sub-module: stall_watchdog, holding the consecutive counter, sticky timeout and saturating stall_cnt.

Test Plan:
- Reset with all requests 1 → stall = 000000, flush = 0, stall_cnt = 0. Release rst → next cycle stall = 011111.
- stallreq_id = 1 and stallreq_if = 1 together for 3 cycles → stall = 000111 each cycle; stall_cnt = 3 afterwards.
- excepttype = 32'h0000_0008 with stallreq_mem = 1 for 2 cycles, then stallreq_mem = 0 → no flush while held. Flush = 1 exactly one cycle after the release cycle, new_pc = 32'h0000_0020.
- excepttype = 32'h0000_000e, cp0_epc = 32'h8000_1234 → flush pulse width 1, new_pc = 32'h8000_1234. stall = 000000 during flush even with stallreq_ex = 1.
- TIMEOUT_CYCLES = 4, stallreq_ex held 4 cycles → timeout = 1 after the 4th stalled cycle. It stays 1 after requests drop until rst.
- Exception asserted in consecutive cycles → flush pulses in cycles N+1 and N+3 only, never two adjacent flush cycles.
